// File: rtl/circuito_exp4.sv
// Memory-sequence game top: control FSM plus datapath (counter, ROM, play register,
// comparator, switch edge detector) with 7-segment debug outputs.
//
// state       | meaning
// inicial     | idle, waits for iniciar
// preparacao  | clears counter and play register
// espera      | waits for a new play (edge on switches)
// registra    | captures the switches into the play register
// comparacao  | compares play with ROM[contagem], decides next step
// proximo     | advances the counter
// fim_acertou | whole sequence matched, waits for iniciar
// fim_errou   | a play mismatched, waits for iniciar
module circuito_exp4 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogada,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } estado_t;

  function automatic logic [3:0] rom_lookup(input logic [3:0] addr);
    case (addr)
      4'h0:    rom_lookup = 4'h1;
      4'h1:    rom_lookup = 4'h2;
      4'h2:    rom_lookup = 4'h4;
      4'h3:    rom_lookup = 4'h8;
      4'h4:    rom_lookup = 4'h4;
      4'h5:    rom_lookup = 4'h2;
      4'h6:    rom_lookup = 4'h1;
      4'h7:    rom_lookup = 4'h1;
      4'h8:    rom_lookup = 4'h2;
      4'h9:    rom_lookup = 4'h2;
      4'hA:    rom_lookup = 4'h4;
      4'hB:    rom_lookup = 4'h4;
      4'hC:    rom_lookup = 4'h8;
      4'hD:    rom_lookup = 4'h8;
      4'hE:    rom_lookup = 4'h1;
      default: rom_lookup = 4'h4;
    endcase
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0:    hex7seg = 7'b1000000;
      4'h1:    hex7seg = 7'b1111001;
      4'h2:    hex7seg = 7'b0100100;
      4'h3:    hex7seg = 7'b0110000;
      4'h4:    hex7seg = 7'b0011001;
      4'h5:    hex7seg = 7'b0010010;
      4'h6:    hex7seg = 7'b0000010;
      4'h7:    hex7seg = 7'b1111000;
      4'h8:    hex7seg = 7'b0000000;
      4'h9:    hex7seg = 7'b0010000;
      4'hA:    hex7seg = 7'b0001000;
      4'hB:    hex7seg = 7'b0000011;
      4'hC:    hex7seg = 7'b1000110;
      4'hD:    hex7seg = 7'b0100001;
      4'hE:    hex7seg = 7'b0000110;
      default: hex7seg = 7'b0001110;
    endcase
  endfunction

  estado_t    estado_q, estado_d;
  logic [3:0] contagem_q, contagem_d;
  logic [3:0] jogada_q, jogada_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;

  logic       zera;
  logic       registra_en;
  logic       conta;
  logic       tem_jogada;
  logic       igual;
  logic       fim_contagem;
  logic [3:0] memoria;

  assign memoria      = rom_lookup(contagem_q);
  assign igual        = (jogada_q == memoria);
  assign fim_contagem = (contagem_q == 4'hF);
  assign tem_jogada   = s0_q & ~s1_q;

  // State register and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= INICIAL;
      contagem_q <= 4'h0;
      jogada_q   <= 4'h0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contagem_q <= contagem_d;
      jogada_q   <= jogada_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:     if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:  estado_d = ESPERA;
      ESPERA:      if (tem_jogada) estado_d = REGISTRA;
      REGISTRA:    estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)            estado_d = FIM_ERROU;
        else if (fim_contagem) estado_d = FIM_ACERTOU;
        else                   estado_d = PROXIMO;
      end
      PROXIMO:     estado_d = ESPERA;
      FIM_ACERTOU: if (iniciar) estado_d = PREPARACAO;
      FIM_ERROU:   if (iniciar) estado_d = PREPARACAO;
      default:     estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zera        = (estado_q == PREPARACAO);
    registra_en = (estado_q == REGISTRA);
    conta       = (estado_q == PROXIMO);
    acertou     = (estado_q == FIM_ACERTOU);
    errou       = (estado_q == FIM_ERROU);
    pronto      = acertou | errou;
  end

  always_comb begin
    contagem_d = contagem_q;
    jogada_d   = jogada_q;
    if (zera) begin
      contagem_d = 4'h0;
      jogada_d   = 4'h0;
    end else begin
      if (conta)       contagem_d = contagem_q + 4'h1;
      if (registra_en) jogada_d   = chaves;
    end
    s0_d = |chaves;
    s1_d = s0_q;
  end

  assign leds          = chaves;
  assign db_igual      = igual;
  assign db_contagem   = hex7seg(contagem_q);
  assign db_memoria    = hex7seg(memoria);
  assign db_estado     = hex7seg(estado_q);
  assign db_jogada     = hex7seg(jogada_q);
  assign db_clock      = clock;
  assign db_iniciar    = iniciar;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_circuito_exp4.sv
// Directed bench for circuito_exp4: a game-level reference model checked every cycle,
// plus literal expectations at the key moments of each scenario.
module tb_circuito_exp4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       acertou, errou, pronto;
  logic [3:0] leds;
  logic       db_igual;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogada;
  logic       db_clock, db_iniciar, db_tem_jogada;

  circuito_exp4 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogada(db_jogada), .db_clock(db_clock),
    .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  logic [3:0] rom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Game model: phase code (doubles as display code), position, last play, switch history
  logic [3:0] m_st = 4'h0;
  logic [3:0] m_cnt = 4'h0;
  logic [3:0] m_jog = 4'h0;
  logic       m_p0 = 1'b0;
  logic       m_p1 = 1'b0;

  always @(posedge clock) begin
    logic pressed;
    pressed = m_p0 & ~m_p1;
    if (reset) begin
      m_st = 4'h0; m_cnt = 4'h0; m_jog = 4'h0; m_p0 = 1'b0; m_p1 = 1'b0;
    end else begin
      case (m_st)
        4'h0, 4'hA, 4'hE: if (iniciar) m_st = 4'h1;
        4'h1: begin m_cnt = 4'h0; m_jog = 4'h0; m_st = 4'h2; end
        4'h2: if (pressed) m_st = 4'h4;
        4'h4: begin m_jog = chaves; m_st = 4'h5; end
        4'h5: begin
          if (m_jog != rom[m_cnt]) m_st = 4'hE;
          else if (m_cnt == 4'd15) m_st = 4'hA;
          else                     m_st = 4'h6;
        end
        4'h6: begin m_cnt = m_cnt + 4'h1; m_st = 4'h2; end
        default: m_st = 4'h0;
      endcase
      m_p1 = m_p0;
      m_p0 = |chaves;
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle_compare();
    logic [6:0] e_est, e_cnt, e_mem, e_jog;
    logic e_ac, e_er, e_pr, e_ig, e_tem;
    e_est = seg[m_st];
    e_cnt = seg[m_cnt];
    e_mem = seg[rom[m_cnt]];
    e_jog = seg[m_jog];
    e_ac  = (m_st == 4'hA);
    e_er  = (m_st == 4'hE);
    e_pr  = e_ac | e_er;
    e_ig  = (m_jog == rom[m_cnt]);
    e_tem = m_p0 & ~m_p1;
    n_total++;
    if (db_estado === e_est && db_contagem === e_cnt && db_memoria === e_mem &&
        db_jogada === e_jog && acertou === e_ac && errou === e_er && pronto === e_pr &&
        db_igual === e_ig && db_tem_jogada === e_tem && leds === chaves &&
        db_iniciar === iniciar && db_clock === clock)
      n_pass++;
    else
      $display("FAIL cycle t=%0t: est %b/%b cnt %b/%b mem %b/%b jog %b/%b ac %b/%b er %b/%b pr %b/%b ig %b/%b tem %b/%b",
               $time, db_estado, e_est, db_contagem, e_cnt, db_memoria, e_mem, db_jogada, e_jog,
               acertou, e_ac, errou, e_er, pronto, e_pr, db_igual, e_ig, db_tem_jogada, e_tem);
  endtask

  // Advance one clock; inputs change only at the falling edge, where outputs are checked
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (db_tem_jogada === 1'b1) pulses++;
    if (chk_en) cycle_compare();
  endtask

  task automatic play(input logic [3:0] v);
    chaves = v;
    repeat (10) tick();
    chaves = 4'h0;
    repeat (10) tick();
  endtask

  task automatic restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_estado", db_estado, 7'b1000000);
    check("reset_contagem", db_contagem, 7'b1000000);
    check("reset_pronto", {acertou, errou, pronto}, 3'b000);

    iniciar = 1'b1;
    repeat (5) tick();
    iniciar = 1'b0;
    check("start_espera", db_estado, 7'b0100100);

    pulses = 0;
    for (int i = 0; i < 16; i++) play(rom[i]);
    check("win_pulses", pulses, 16);
    check("win_flags", {acertou, errou, pronto}, 3'b101);
    check("win_estado", db_estado, 7'b0001000);
    check("model_win", m_st, 4'hA);

    restart();
    check("restart1_contagem", db_contagem, 7'b1000000);
    play(4'h1); play(4'h2); play(4'h4); play(4'h8); play(4'h8);
    check("lose_flags", {acertou, errou, pronto}, 3'b011);
    check("lose_estado", db_estado, 7'b0000110);
    check("lose_contagem", db_contagem, 7'b0011001);

    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("replay_prep", db_estado, 7'b1111001);
    tick();
    check("replay_contagem", db_contagem, 7'b1000000);
    check("replay_espera", db_estado, 7'b0100100);
    for (int i = 0; i < 16; i++) play(rom[i]);
    check("replay_win", {acertou, errou, pronto}, 3'b101);

    restart();
    for (int i = 0; i < 7; i++) play(rom[i]);
    check("mid_contagem7", db_contagem, 7'b1111000);
    check("mid_espera", db_estado, 7'b0100100);
    reset = 1'b1;
    iniciar = 1'b1;
    chaves = 4'h1;
    tick();
    reset = 1'b0;
    iniciar = 1'b0;
    chaves = 4'h0;
    check("midreset_estado", db_estado, 7'b1000000);
    check("midreset_contagem", db_contagem, 7'b1000000);
    check("midreset_jogada", db_jogada, 7'b1000000);
    check("midreset_pronto", pronto, 1'b0);
    repeat (3) tick();
    check("idle_after_reset", db_estado, 7'b1000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
